// File: rtl/cpu_prog_load_check.sv
// cpu_prog_load_check: streams a program ROM into the CPU, drains, then checks result lanes against a golden ROM
module cpu_prog_load_check #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned PROG_LEN     = 256,
    parameter int unsigned RES_WORDS    = 64,
    parameter int unsigned LANES        = 4,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned BASE_ADDR    = 8,
    parameter int unsigned DRAIN_CYCLES = 16,
    parameter int unsigned ERR_W        = 8,
    localparam int unsigned PW = (PROG_LEN > 1) ? $clog2(PROG_LEN) : 1,
    localparam int unsigned GW = (RES_WORDS > 1) ? $clog2(RES_WORDS) : 1,
    localparam int unsigned LW = $clog2(LANES)
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic              start_i,
    input  logic              abort_i,
    output logic [PW-1:0]     prog_addr_o,
    input  logic [DATA_W-1:0] prog_data_i,
    output logic [GW-1:0]     gold_addr_o,
    input  logic [DATA_W-1:0] gold_data_i,
    output logic [DATA_W-1:0] instr_o,
    output logic              data_or_reg_o,
    output logic [ADDR_W-1:0] address_o,
    output logic [LW-1:0]     vout_addr_o,
    input  logic [DATA_W-1:0] value_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ERR_W-1:0]  err_cnt_o,
    output logic [GW-1:0]     first_err_o
);
    localparam int unsigned M1   = (PROG_LEN > RES_WORDS) ? PROG_LEN : RES_WORDS;
    localparam int unsigned M2   = (DRAIN_CYCLES > LANES) ? DRAIN_CYCLES : LANES;
    localparam int unsigned MAXN = (M1 > M2) ? M1 : M2;
    localparam int unsigned CW   = $clog2(MAXN + 1);

    // LAST is the compare-only cycle after the final readback has been issued
    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, CHECK, LAST, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     prog_addr_q, prog_addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              cmp_vld_q, cmp_vld_d;
    logic [GW-1:0]     cmp_idx_q, cmp_idx_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [GW-1:0]     first_q, first_d;
    logic [CW-1:0]     j;

    // readback index is only live in CHECK; elsewhere it parks at 0 so lane outputs sit at reset values
    always_comb j = (state_q == CHECK) ? cnt_q : '0;

    // next-state, counters and compare stage; the program address runs one ahead to hide ROM latency
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prog_addr_d = prog_addr_q;
        instr_d     = instr_q;
        cmp_vld_d   = 1'b0;
        cmp_idx_d   = j[GW-1:0];
        err_d       = err_q;
        first_d     = first_q;
        if (cmp_vld_q && value_i != gold_data_i) begin
            err_d   = &err_q ? err_q : err_q + 1'b1;
            first_d = &first_q ? cmp_idx_q : first_q;
        end
        case (state_q)
            IDLE, DONE: if (start_i) begin
                state_d     = LOAD;
                cnt_d       = '0;
                prog_addr_d = PW'(PROG_LEN > 1);
                err_d       = '0;
                first_d     = '1;
            end
            LOAD: begin
                instr_d     = prog_data_i;
                prog_addr_d = (prog_addr_q == PW'(PROG_LEN - 1) || prog_addr_q == '0) ? '0 : prog_addr_q + 1'b1;
                cnt_d       = (cnt_q == CW'(PROG_LEN - 1)) ? '0 : cnt_q + 1'b1;
                state_d     = (cnt_q == CW'(PROG_LEN - 1)) ? DRAIN : LOAD;
            end
            DRAIN: begin
                instr_d = '0;
                cnt_d   = (cnt_q == CW'(DRAIN_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == CW'(DRAIN_CYCLES - 1)) ? CHECK : DRAIN;
            end
            CHECK: begin
                cmp_vld_d = 1'b1;
                cnt_d     = (cnt_q == CW'(RES_WORDS - 1)) ? '0 : cnt_q + 1'b1;
                state_d   = (cnt_q == CW'(RES_WORDS - 1)) ? LAST : CHECK;
            end
            LAST:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (abort_i) begin
            state_d     = IDLE;
            cnt_d       = '0;
            prog_addr_d = '0;
            instr_d     = '0;
            cmp_vld_d   = 1'b0;
            err_d       = err_q;
            first_d     = first_q;
        end
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prog_addr_q <= '0;
            instr_q     <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_idx_q   <= '0;
            err_q       <= '0;
            first_q     <= '1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prog_addr_q <= prog_addr_d;
            instr_q     <= instr_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_idx_q   <= cmp_idx_d;
            err_q       <= err_d;
            first_q     <= first_d;
        end
    end

    assign prog_addr_o   = prog_addr_q;
    assign gold_addr_o   = j[GW-1:0];
    assign instr_o       = instr_q;
    assign data_or_reg_o = 1'b1;
    assign address_o     = ADDR_W'(BASE_ADDR) + ADDR_W'(j >> LW);
    assign vout_addr_o   = ~j[LW-1:0];
    assign busy_o        = state_q inside {LOAD, DRAIN, CHECK, LAST};
    assign done_o        = state_q == DONE;
    assign pass_o        = done_o && err_q == '0;
    assign err_cnt_o     = err_q;
    assign first_err_o   = first_q;
endmodule

// File: tb/tb_cpu_prog_load_check.sv
// tb_cpu_prog_load_check: table-driven and random checks of loader timing, lane walk and error reporting
module tb_cpu_prog_load_check;
    localparam int D      = 3;
    localparam int T_CHK  = 4 + D;
    localparam int T_DONE = T_CHK + 9;

    typedef struct {
        logic [31:0] prog;
        logic [63:0] res;
        logic [7:0]  mask;
        int          e;
        int          f;
        int          p;
        int          eb;
    } vec_t;

    logic clk = 0, rst = 0, start = 0, abort = 0;
    always #5 clk = ~clk;

    logic [1:0] pa_a, pa_b, vo_a, vo_b, ec_b;
    logic [2:0] ga_a, ga_b, fe_a, fe_b;
    logic [7:0] ins_a, ins_b, ec_a;
    logic [4:0] ad_a, ad_b;
    logic       dor_a, dor_b, bz_a, bz_b, dn_a, dn_b, ps_a, ps_b;
    logic [7:0] prog_data, gold_data, value;
    logic [7:0] prog_rom [4];
    logic [7:0] gold_rom [8];
    logic [7:0] mem [32][4];

    cpu_prog_load_check #(.DATA_W(8), .PROG_LEN(4), .RES_WORDS(8), .LANES(4), .ADDR_W(5),
        .BASE_ADDR(8), .DRAIN_CYCLES(D), .ERR_W(8)) dut_a (
        .clk_i(clk), .reset(rst), .start_i(start), .abort_i(abort),
        .prog_addr_o(pa_a), .prog_data_i(prog_data), .gold_addr_o(ga_a), .gold_data_i(gold_data),
        .instr_o(ins_a), .data_or_reg_o(dor_a), .address_o(ad_a), .vout_addr_o(vo_a), .value_i(value),
        .busy_o(bz_a), .done_o(dn_a), .pass_o(ps_a), .err_cnt_o(ec_a), .first_err_o(fe_a));

    cpu_prog_load_check #(.DATA_W(8), .PROG_LEN(4), .RES_WORDS(8), .LANES(4), .ADDR_W(5),
        .BASE_ADDR(31), .DRAIN_CYCLES(D), .ERR_W(2)) dut_b (
        .clk_i(clk), .reset(rst), .start_i(start), .abort_i(abort),
        .prog_addr_o(pa_b), .prog_data_i(prog_data), .gold_addr_o(ga_b), .gold_data_i(gold_data),
        .instr_o(ins_b), .data_or_reg_o(dor_b), .address_o(ad_b), .vout_addr_o(vo_b), .value_i(value),
        .busy_o(bz_b), .done_o(dn_b), .pass_o(ps_b), .err_cnt_o(ec_b), .first_err_o(fe_b));

    // synchronous ROMs and CPU register file, all with one cycle of read latency
    always @(posedge clk) begin
        prog_data <= prog_rom[pa_a];
        gold_data <= gold_rom[ga_a];
        value     <= mem[ad_a][vo_a];
    end

    int errors = 0, checks = 0;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] prog, input logic [63:0] res, input logic [7:0] mask);
        vec_t v;
        v.prog = prog;
        v.res  = res;
        v.mask = mask;
        v.e    = 0;
        v.f    = 7;
        for (int i = 7; i >= 0; i--) if (mask[i]) begin
            v.e++;
            v.f = i;
        end
        v.p  = (v.e == 0);
        v.eb = (v.e > 3) ? 3 : v.e;
        return v;
    endfunction

    task automatic load(input vec_t v);
        for (int k = 0; k < 4; k++) prog_rom[k] = v.prog[8*k +: 8];
        for (int a = 0; a < 32; a++) for (int l = 0; l < 4; l++) mem[a][l] = 8'(a * 4 + l) ^ 8'hC3;
        for (int i = 0; i < 8; i++) begin
            mem[(8 + i / 4) % 32][3 - i % 4] = v.res[8*i +: 8];
            gold_rom[i] = v.mask[i] ? v.res[8*i +: 8] ^ 8'h5A : v.res[8*i +: 8];
        end
    endtask

    task automatic chk_idle(input string tag, input int e, input int f);
        chk({tag, ".instr"}, ins_a, 0);
        chk({tag, ".dor"}, dor_a, 1);
        chk({tag, ".addr_a"}, ad_a, 8);
        chk({tag, ".addr_b"}, ad_b, 31);
        chk({tag, ".vout"}, vo_a, 3);
        chk({tag, ".prog_addr"}, pa_a, 0);
        chk({tag, ".gold_addr"}, ga_a, 0);
        chk({tag, ".busy"}, bz_a, 0);
        chk({tag, ".done"}, dn_a, 0);
        chk({tag, ".pass"}, ps_a, 0);
        chk({tag, ".err"}, ec_a, e);
        chk({tag, ".first"}, fe_a, f);
        chk({tag, ".err_b"}, ec_b, (e > 3) ? 3 : e);
    endtask

    task automatic chk_lane(input string tag, input int j);
        chk({tag, ".addr_a"}, ad_a, 8 + j / 4);
        chk({tag, ".addr_b"}, ad_b, (31 + j / 4) % 32);
        chk({tag, ".vout"}, vo_a, 3 - j % 4);
        chk({tag, ".gold_addr"}, ga_a, j);
    endtask

    task automatic run(input vec_t v, input string tag);
        load(v);
        start = 1;
        @(negedge clk);
        start = 0;
        for (int c = 0; c <= T_DONE + 1; c++) begin
            logic [7:0] exp_ins;
            exp_ins = 0;
            if (c >= 1 && c <= 4) exp_ins = v.prog[8*(c-1) +: 8];
            chk({tag, ".busy"}, bz_a, c < T_DONE);
            chk({tag, ".busy_b"}, bz_b, c < T_DONE);
            chk({tag, ".done"}, dn_a, c >= T_DONE);
            chk({tag, ".instr"}, ins_a, exp_ins);
            if (c >= T_CHK && c < T_CHK + 8) chk_lane(tag, c - T_CHK);
            @(negedge clk);
        end
        chk({tag, ".err"}, ec_a, v.e);
        chk({tag, ".first"}, fe_a, v.f);
        chk({tag, ".pass"}, ps_a, v.p);
        chk({tag, ".err_b"}, ec_b, v.eb);
        chk({tag, ".first_b"}, fe_b, v.f);
        chk({tag, ".pass_b"}, ps_b, v.p);
    endtask

    initial begin
        tbl[0] = mk(32'h2C21160B, 64'h8877665544332211, 8'h00);
        tbl[1] = mk(32'h2C21160B, 64'h0F1E2D3C4B5A6978, 8'h60);
        tbl[2] = mk(32'hA1B2C3D4, 64'h1122334455667788, 8'hFF);
        for (int i = 3; i < 8; i++) tbl[i] = mk($urandom, {$urandom, $urandom}, 8'($urandom));
        for (int k = 0; k < 4; k++) prog_rom[k] = 0;
        for (int i = 0; i < 8; i++) gold_rom[i] = 0;
        for (int a = 0; a < 32; a++) for (int l = 0; l < 4; l++) mem[a][l] = 0;

        rst = 1;
        @(negedge clk);
        chk_idle("reset", 0, 7);
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run(tbl[i], $sformatf("vec%0d", i));

        // abort during LOAD word 2; a start while busy must not restart the stream
        load(tbl[0]);
        start = 1;
        @(negedge clk);
        @(negedge clk);
        start = 0;
        chk("abl.instr1", ins_a, 11);
        @(negedge clk);
        chk("abl.instr2", ins_a, 22);
        chk("abl.busy", bz_a, 1);
        abort = 1;
        start = 1;
        @(negedge clk);
        abort = 0;
        start = 0;
        chk_idle("abl.c3", 0, 7);
        @(negedge clk);
        chk_idle("abl.c4", 0, 7);

        // abort mid-CHECK holds the error status; an ignored start must not clear it
        load(mk(32'h2C21160B, 64'h8877665544332211, 8'h07));
        start = 1;
        @(negedge clk);
        start = 0;
        for (int c = 0; c < 9; c++) @(negedge clk);
        chk("abc.err9", ec_a, 1);
        start = 1;
        @(negedge clk);
        chk("abc.err10", ec_a, 2);
        chk("abc.busy10", bz_a, 1);
        chk_lane("abc.c10", 3);
        abort = 1;
        @(negedge clk);
        abort = 0;
        start = 0;
        chk_idle("abc.c11", 2, 0);
        @(negedge clk);
        chk_idle("abc.c12", 2, 0);

        // asynchronous reset mid-CHECK, then a clean full pass
        load(mk(32'h2C21160B, 64'h8877665544332211, 8'h01));
        start = 1;
        @(negedge clk);
        start = 0;
        for (int c = 0; c < 10; c++) @(negedge clk);
        chk("rst.err", ec_a, 1);
        chk_lane("rst.c10", 3);
        #2 rst = 1;
        #1 chk_idle("rst.async", 0, 7);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        run(tbl[0], "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
